rainbow_scroll_gen: RTL and testbench



---
 rtl/rainbow_scroll_gen_if.sv | 31 +++
 rtl/rainbow_scroll_gen.sv | 128 ++++++++++++
 tb/tb_rainbow_scroll_gen.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rainbow_scroll_gen_if.sv
// ============================================================================
// Module : rainbow_scroll_gen_if
// Desc   : Pixel, colour-ROM and status signals of the rainbow scroll stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rainbow_scroll_gen_if;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        frame_tick;
  logic        mode_btn;
  logic [4:0]  rom_addr;
  logic [11:0] rom_data;
  logic [11:0] rgb;
  logic [1:0]  mode;

  // Environment side: sync generator, button, colour ROM and RGB sink.
  modport master (
    output pixel_x, pixel_y, video_on, frame_tick, mode_btn, rom_data,
    input  rom_addr, rgb, mode
  );

  modport slave (
    input  pixel_x, pixel_y, video_on, frame_tick, mode_btn, rom_data,
    output rom_addr, rgb, mode
  );
endinterface

`default_nettype wire

// File: rtl/rainbow_scroll_gen.sv
// ============================================================================
// Module : rainbow_scroll_gen
// Desc   : Scrolling rainbow pixel stage; maps pixel to ROM address, blanks
//          the returned colour. Define RAINBOW_DIAGONAL_EN for diagonal bands.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rainbow_scroll_gen #(
  parameter int unsigned BAND_SHIFT = 4,
  parameter int unsigned SPEED_DIV  = 2
) (
  input  wire logic            clk,
  input  wire logic            reset,
  rainbow_scroll_gen_if.slave  bus
);

  localparam logic [1:0] SCROLL_RIGHT = 2'b00;
  localparam logic [1:0] SCROLL_LEFT  = 2'b01;
  localparam logic [1:0] PAUSED       = 2'b10;
  localparam logic [7:0] DIV_LAST     = 8'(SPEED_DIV - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  offset_q, offset_d;
  logic [4:0]  rom_addr_q, rom_addr_d;
  logic        von_d1_q, von_d1_d;
  logic        von_d2_q, von_d2_d;
  logic [11:0] rgb_q, rgb_d;
  logic [1:0]  mode_o;

  logic [9:0]  band_x;
  logic [9:0]  addr_sum;
  logic        scroll_right;
  logic        scroll_left;
  logic        unused_sum_hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SCROLL_RIGHT;
      div_q      <= '0;
      offset_q   <= '0;
      rom_addr_q <= '0;
      von_d1_q   <= 1'b0;
      von_d2_q   <= 1'b0;
      rgb_q      <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      offset_q   <= offset_d;
      rom_addr_q <= rom_addr_d;
      von_d1_q   <= von_d1_d;
      von_d2_q   <= von_d2_d;
      rgb_q      <= rgb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCROLL_RIGHT: if (bus.mode_btn) state_d = SCROLL_LEFT;
      SCROLL_LEFT:  if (bus.mode_btn) state_d = PAUSED;
      PAUSED:       if (bus.mode_btn) state_d = SCROLL_RIGHT;
      default:      state_d = bus.mode_btn ? SCROLL_LEFT : SCROLL_RIGHT;
    endcase
  end

  always_comb begin
    mode_o = (state_q == 2'b11) ? SCROLL_RIGHT : state_q;
  end

  assign bus.mode = mode_o;

  // The step is decided from the current state, even when a mode change
  // lands on the same edge; a paused or entering-paused divider reads zero.
  always_comb begin
    scroll_right = (state_q == SCROLL_RIGHT) || (state_q == 2'b11);
    scroll_left  = (state_q == SCROLL_LEFT);
    div_d        = div_q;
    offset_d     = offset_q;
    if (bus.frame_tick && (scroll_right || scroll_left)) begin
      if (div_q == DIV_LAST) begin
        div_d    = '0;
        offset_d = scroll_right ? offset_q + 5'd1 : offset_q - 5'd1;
      end else begin
        div_d    = div_q + 8'd1;
      end
    end
    if (state_d == PAUSED) begin
      div_d = '0;
    end
  end

`ifdef RAINBOW_DIAGONAL_EN
  logic [9:0] band_y;

  always_comb begin
    band_x   = bus.pixel_x >> BAND_SHIFT;
    band_y   = bus.pixel_y >> BAND_SHIFT;
    addr_sum = band_x + band_y + {5'b0, offset_q};
  end
`else
  logic unused_pixel_y;

  assign unused_pixel_y = ^bus.pixel_y;

  always_comb begin
    band_x   = bus.pixel_x >> BAND_SHIFT;
    addr_sum = band_x + {5'b0, offset_q};
  end
`endif

  assign unused_sum_hi = ^addr_sum[9:5];

  // video_on is delayed twice so it lines up with rom_data at the rgb stage.
  always_comb begin
    rom_addr_d = addr_sum[4:0];
    von_d1_d   = bus.video_on;
    von_d2_d   = von_d1_q;
    rgb_d      = von_d2_q ? bus.rom_data : 12'h000;
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.rgb      = rgb_q;

endmodule

`default_nettype wire

// File: tb/tb_rainbow_scroll_gen.sv
// ============================================================================
// Module : tb_rainbow_scroll_gen
// Desc   : Self-checking bench for rainbow_scroll_gen with a behavioural ROM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rainbow_scroll_gen;
  localparam int BAND_SHIFT = 4;
  localparam int SPEED_DIV  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  rainbow_scroll_gen_if bus ();

  rainbow_scroll_gen #(.BAND_SHIFT(BAND_SHIFT), .SPEED_DIV(SPEED_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_lut(input logic [4:0] a);
    case (a)
      5'd0:    return 12'hF00;
      5'd2:    return 12'hE30;
      default: return 12'(a * 12'h111) ^ 12'h5A5;
    endcase
  endfunction

  // Colour ROM: one cycle of read latency.
  always @(posedge clk) bus.rom_data <= rom_lut(bus.rom_addr);

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: mode as 0/1/2, offset in 0..31, ticks counted mod SPEED_DIV.
  int          m_mode = 0;
  int          m_off  = 0;
  int          m_acc  = 0;
  logic [4:0]  m_addr = '0;
  logic [11:0] m_rgb  = '0;
  logic [11:0] m_p1   = '0;
  logic [11:0] m_p2   = '0;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [9:0] x, input logic [9:0] y,
                            input logic v, input logic f, input logic b);
    int a;
    if (r) begin
      m_mode = 0; m_off = 0; m_acc = 0;
      m_addr = '0; m_rgb = '0; m_p1 = '0; m_p2 = '0;
    end else begin
      a = (int'(x) / 16 + m_off) % 32;
`ifdef RAINBOW_DIAGONAL_EN
      a = (a + int'(y) / 16) % 32;
`endif
      m_rgb  = m_p2;
      m_p2   = m_p1;
      m_p1   = v ? rom_lut(5'(a)) : 12'h000;
      m_addr = 5'(a);
      if (f && m_mode != 2) begin
        m_acc = (m_acc + 1) % SPEED_DIV;
        if (m_acc == 0) m_off = (m_mode == 0) ? (m_off + 1) % 32 : (m_off + 31) % 32;
      end
      if (b) begin
        m_mode = (m_mode + 1) % 3;
        if (m_mode == 2) m_acc = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic [9:0] x, input logic [9:0] y,
                      input logic v, input logic f, input logic b);
    @(negedge clk);
    reset          = r;
    bus.pixel_x    = x;
    bus.pixel_y    = y;
    bus.video_on   = v;
    bus.frame_tick = f;
    bus.mode_btn   = b;
    @(posedge clk);
    model_edge(r, x, y, v, f, b);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [9:0]  x;
    logic        v;
    logic        f;
    logic        b;
    logic [4:0]  ea;
    logic [11:0] er;
    logic [1:0]  em;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bus.pixel_x = '0; bus.pixel_y = '0; bus.video_on = 1'b0;
    bus.frame_tick = 1'b0; bus.mode_btn = 1'b0;

    tbl[0] = '{1'b1, 10'd0,  1'b1, 1'b0, 1'b0, 5'd0, 12'h000, 2'b00};
    tbl[1] = '{1'b0, 10'd0,  1'b1, 1'b0, 1'b0, 5'd0, 12'h000, 2'b00};
    tbl[2] = '{1'b0, 10'd37, 1'b1, 1'b0, 1'b0, 5'd2, 12'h000, 2'b00};
    tbl[3] = '{1'b0, 10'd37, 1'b0, 1'b0, 1'b0, 5'd2, 12'hF00, 2'b00};
    tbl[4] = '{1'b0, 10'd37, 1'b0, 1'b0, 1'b0, 5'd2, 12'hE30, 2'b00};
    tbl[5] = '{1'b0, 10'd37, 1'b0, 1'b0, 1'b0, 5'd2, 12'h000, 2'b00};

    for (int i = 0; i < 6; i++) begin
      step(tbl[i].rst, tbl[i].x, 10'd0, tbl[i].v, tbl[i].f, tbl[i].b);
      chk($sformatf("tbl%0d_addr", i), 12'(bus.rom_addr), 12'(tbl[i].ea));
      chk($sformatf("tbl%0d_rgb", i),  bus.rgb,            tbl[i].er);
      chk($sformatf("tbl%0d_mode", i), 12'(bus.mode),      12'(tbl[i].em));
    end

    // Scroll right: 62 ticks leave offset at 31, two more wrap it to 0.
    for (int i = 0; i < 62; i++) step(1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    chk("right62_addr", 12'(bus.rom_addr), 12'd31);
    for (int i = 0; i < 2; i++) step(1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    chk("right64_addr", 12'(bus.rom_addr), 12'd0);

    // Scroll left two ticks, then pause and tick ten times.
    step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    chk("left_mode", 12'(bus.mode), 12'd1);
    for (int i = 0; i < 2; i++) step(1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    chk("left_wrap_addr", 12'(bus.rom_addr), 12'd31);
    step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    chk("paused_mode", 12'(bus.mode), 12'd2);
    for (int i = 0; i < 10; i++) step(1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    chk("paused_addr", 12'(bus.rom_addr), 12'd31);
    chk("paused_mode2", 12'(bus.mode), 12'd2);

    // Back to right; tick once, then tick and button together.
    step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    chk("right_again_mode", 12'(bus.mode), 12'd0);
    step(1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    chk("simul_mode", 12'(bus.mode), 12'd1);
    step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    chk("simul_addr", 12'(bus.rom_addr), 12'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), 10'($urandom_range(0, 1023)),
           10'($urandom_range(0, 1023)), 1'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0));
      chk("rand_addr", 12'(bus.rom_addr), 12'(m_addr));
      chk("rand_rgb",  bus.rgb,           m_rgb);
      chk("rand_mode", 12'(bus.mode),     12'(m_mode));
    end

    // Reset mid-line, with a button press that must be ignored.
    step(1'b1, 10'd300, 10'd100, 1'b1, 1'b1, 1'b1);
    chk("midrst_addr", 12'(bus.rom_addr), 12'd0);
    chk("midrst_rgb",  bus.rgb,           12'h000);
    chk("midrst_mode", 12'(bus.mode),     12'd0);
    step(1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
    chk("postrst_rgb1", bus.rgb, 12'h000);
    step(1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
    chk("postrst_rgb2", bus.rgb, 12'h000);
    step(1'b0, 10'd16, 10'd48, 1'b1, 1'b0, 1'b0);
    chk("postrst_rgb3", bus.rgb, 12'hF00);
`ifdef RAINBOW_DIAGONAL_EN
    chk("diag_addr", 12'(bus.rom_addr), 12'd4);
`else
    chk("vert_addr", 12'(bus.rom_addr), 12'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
